// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types, widths and helpers for the mux scan sequencer
// Contents:
//   state_e   FSM states (IDLE, SCAN)
//   NUM_CH    number of mux channels
//   SEL_W     select width
//   CNT_W     settle counter width
//   lowest()  index of the lowest set bit of a channel mask (0 for an empty mask)
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic {IDLE, SCAN} state_e;

  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest = SEL_W'(i);
  endfunction
endpackage

// File: rtl/mux_next_ch.sv
// mux_next_ch: combinational channel walker over an enable mask
// Ports:
//   mask_i[3:0]   channel enables
//   sel_i[1:0]    current channel
//   first_o[1:0]  lowest enabled channel
//   next_o[1:0]   lowest enabled channel strictly above sel_i
//   last_o        no enabled channel above sel_i
module mux_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [SEL_W-1:0]  first_o,
  output logic [SEL_W-1:0]  next_o,
  output logic              last_o
);
  logic [NUM_CH-1:0] above;

  // The shift drops bits off the top, so there is never a wrap back to channel 0
  assign above   = mask_i & ({{(NUM_CH-1){1'b1}}, 1'b0} << sel_i);
  assign first_o = lowest(mask_i);
  assign next_o  = lowest(above);
  assign last_o  = ~|above;
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: scans the 4:1 mux channel by channel and assembles a 4-bit sample frame
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        frame request, honoured only in IDLE with a non-zero mask
//   continuous   start the next frame on the edge that completes the current one
//   mask[3:0]    channel enables, latched only at frame boundaries
//   y_in         mux output Y
//   sel[1:0]     mux select, sel[1]->S1, sel[0]->S0
//   busy         a frame is in progress
//   sample[3:0]  last completed frame, disabled channels read 0
//   valid        one-cycle pulse when sample updates
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] mask,
  input  logic              y_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [NUM_CH-1:0] sample,
  output logic              valid
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [NUM_CH-1:0] merged;
  logic [SEL_W-1:0]  first_new, next_ch, first_cur, next_new;
  logic              last, last_new, restart;
  logic              unused_ok;

  // Walker over the latched mask drives the in-frame advance
  mux_next_ch u_cur (
    .mask_i  (mask_q),
    .sel_i   (sel_q),
    .first_o (first_cur),
    .next_o  (next_ch),
    .last_o  (last)
  );

  // Walker over the live mask picks the opening channel of a new frame
  mux_next_ch u_new (
    .mask_i  (mask),
    .sel_i   ('0),
    .first_o (first_new),
    .next_o  (next_new),
    .last_o  (last_new)
  );

  assign unused_ok = ^{first_cur, next_new, last_new};

  // Shadow with the channel being captured this cycle folded in
  assign merged  = shadow_q | (NUM_CH'(y_in) << sel_q);
  assign restart = continuous && |mask;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start && |mask) begin
        state_d  = SCAN;
        mask_d   = mask;
        sel_d    = first_new;
        cnt_d    = RELOAD;
        shadow_d = '0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!last) begin
      shadow_d = merged;
      sel_d    = next_ch;
      cnt_d    = RELOAD;
    end else begin
      // Frame end: publish, then either roll straight into the next frame or park
      sample_d = merged;
      valid_d  = 1'b1;
      shadow_d = '0;
      mask_d   = mask;
      sel_d    = restart ? first_new : '0;
      cnt_d    = restart ? RELOAD : '0;
      state_d  = restart ? SCAN : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sel    = sel_q;
  assign busy   = (state_q == SCAN);
  assign sample = sample_q;
  assign valid  = valid_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed table, corner sequences and random run against a frame-level model
module tb_mux_scan_sequencer;
  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 0, rst = 1, start = 0, continuous = 0, use_mux = 0;
  logic [3:0] mask = 0, ivec = 0;
  logic y_rnd0 = 0, y_rnd1 = 0, y0, y1;
  logic [1:0] sel0, sel1;
  logic busy0, busy1, valid0, valid1;
  logic [3:0] sample0, sample1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // Behaves like the 4:1 mux in directed tests, free-running random data otherwise
  assign y0 = use_mux ? ivec[sel0] : y_rnd0;
  assign y1 = use_mux ? ivec[sel1] : y_rnd1;

  mux_scan_sequencer #(.SETTLE(S0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mask(mask),
    .y_in(y0), .sel(sel0), .busy(busy0), .sample(sample0), .valid(valid0)
  );

  mux_scan_sequencer #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mask(mask),
    .y_in(y1), .sel(sel1), .busy(busy1), .sample(sample1), .valid(valid1)
  );

  function automatic void chk(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Frame model: a frame is a list of enabled channels; with e edges elapsed since
  // the accepting edge, channel list[e/S] is selected and every S-th edge captures one.
  bit         m_busy[2], m_valid[2];
  int         m_e[2], m_n[2];
  int         m_list[2][4];
  logic [3:0] m_shadow[2], m_sample[2];
  logic [1:0] m_sel[2];
  logic       h_start, h_cont, h_y[2];
  logic [3:0] h_mask;

  function automatic int settle(int d);
    return d == 0 ? S0 : S1;
  endfunction

  function automatic void open_frame(int d, logic [3:0] m);
    m_n[d] = 0;
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        m_list[d][m_n[d]] = i;
        m_n[d]++;
      end
    m_e[d] = 0;
    m_shadow[d] = 0;
    m_busy[d] = 1;
  endfunction

  function automatic void model_edge(int d);
    m_valid[d] = 0;
    if (!m_busy[d]) begin
      if (h_start && h_mask != 0) open_frame(d, h_mask);
    end else begin
      m_e[d]++;
      if (m_e[d] % settle(d) == 0) begin
        int k = m_e[d] / settle(d) - 1;
        m_shadow[d][m_list[d][k]] = h_y[d];
        if (k == m_n[d] - 1) begin
          m_sample[d] = m_shadow[d];
          m_valid[d] = 1;
          if (h_cont && h_mask != 0) open_frame(d, h_mask);
          else m_busy[d] = 0;
        end
      end
    end
    m_sel[d] = m_busy[d] ? 2'(m_list[d][m_e[d] / settle(d)]) : 2'd0;
  endfunction

  // Inputs only change at posedge+2, so the negedge snapshot is what the DUT samples
  always @(negedge clk) begin
    h_start = start;
    h_cont = continuous;
    h_mask = mask;
    h_y[0] = y0;
    h_y[1] = y1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0;
        m_valid[d] = 0;
        m_sample[d] = 0;
        m_shadow[d] = 0;
        m_sel[d] = 0;
        m_e[d] = 0;
      end
    end else begin
      model_edge(0);
      model_edge(1);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m0.sel", sel0, m_sel[0]);
    chk("m0.busy", busy0, m_busy[0]);
    chk("m0.sample", sample0, m_sample[0]);
    chk("m0.valid", valid0, m_valid[0]);
    chk("m1.sel", sel1, m_sel[1]);
    chk("m1.busy", busy1, m_busy[1]);
    chk("m1.sample", sample1, m_sample[1]);
    chk("m1.valid", valid1, m_valid[1]);
  end

  typedef struct {
    logic       start;
    logic [3:0] mask;
    logic [3:0] ivec;
    logic [1:0] sel;
    logic       busy;
    logic       valid;
    logic [3:0] sample;
  } vec_t;

  vec_t tbl[16];

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full frame I0..I3=0,1,0,1, then start with empty mask, then masked frame
    tbl[0]  = '{1'b1, 4'hF, 4'hA, 2'd0, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 4'hF, 4'hA, 2'd0, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 4'hA, 2'd1, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 4'hA, 2'd1, 1'b1, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 4'hF, 4'hA, 2'd2, 1'b1, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 4'hF, 4'hA, 2'd2, 1'b1, 1'b0, 4'h0};
    tbl[6]  = '{1'b0, 4'hF, 4'hA, 2'd3, 1'b1, 1'b0, 4'h0};
    tbl[7]  = '{1'b0, 4'hF, 4'hA, 2'd3, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 4'hF, 4'hA, 2'd0, 1'b0, 1'b1, 4'hA};
    tbl[9]  = '{1'b1, 4'h0, 4'hA, 2'd0, 1'b0, 1'b0, 4'hA};
    tbl[10] = '{1'b1, 4'h5, 4'hF, 2'd0, 1'b1, 1'b0, 4'hA};
    tbl[11] = '{1'b0, 4'h5, 4'hF, 2'd0, 1'b1, 1'b0, 4'hA};
    tbl[12] = '{1'b0, 4'h5, 4'hF, 2'd2, 1'b1, 1'b0, 4'hA};
    tbl[13] = '{1'b0, 4'h5, 4'hF, 2'd2, 1'b1, 1'b0, 4'hA};
    tbl[14] = '{1'b1, 4'h5, 4'hF, 2'd0, 1'b0, 1'b1, 4'h5};
    tbl[15] = '{1'b0, 4'h5, 4'hF, 2'd0, 1'b0, 1'b0, 4'h5};

    // Reset with random inputs
    repeat (3) begin
      start = 1'($urandom);
      continuous = 1'($urandom);
      mask = 4'($urandom);
      y_rnd0 = 1'($urandom);
      y_rnd1 = 1'($urandom);
      edge1();
      chk("rst.sel", sel0, 0);
      chk("rst.busy", busy0, 0);
      chk("rst.sample", sample0, 0);
      chk("rst.valid", valid0, 0);
      #1;
    end
    rst = 0;
    start = 0;
    continuous = 0;
    mask = 0;
    use_mux = 1;

    for (int r = 0; r < 16; r++) begin
      start = tbl[r].start;
      mask = tbl[r].mask;
      ivec = tbl[r].ivec;
      edge1();
      chk($sformatf("tbl%0d.sel", r), sel0, tbl[r].sel);
      chk($sformatf("tbl%0d.busy", r), busy0, tbl[r].busy);
      chk($sformatf("tbl%0d.valid", r), valid0, tbl[r].valid);
      chk($sformatf("tbl%0d.sample", r), sample0, tbl[r].sample);
      #1;
    end
    start = 0;
    repeat (4) begin
      edge1();
      #1;
    end

    // Continuous: valid every 8 edges, wrap 11->00 without a gap, drop mid-frame
    mask = 4'hF;
    ivec = 4'h5;
    continuous = 1;
    start = 1;
    for (int c = 0; c <= 32; c++) begin
      edge1();
      chk($sformatf("cont%0d.valid", c), valid0, (c == 8 || c == 16 || c == 24) ? 4'd1 : 4'd0);
      if (c == 7) chk("cont.last_sel", sel0, 3);
      if (c == 8) begin
        chk("cont.wrap_sel", sel0, 0);
        chk("cont.wrap_busy", busy0, 1);
      end
      if (c == 16) chk("cont.sample", sample0, 4'h5);
      #1;
      start = 0;
      if (c == 18) continuous = 0;
    end
    chk("cont.idle", busy0, 0);

    // start pulses and mask change while busy must not disturb the frame
    mask = 4'hF;
    ivec = 4'h6;
    start = 1;
    for (int c = 0; c <= 10; c++) begin
      edge1();
      chk($sformatf("busy%0d.valid", c), valid0, (c == 8) ? 4'd1 : 4'd0);
      if (c == 8) chk("busy.sample", sample0, 4'h6);
      #1;
      start = (c >= 2 && c <= 4);
      mask = (c >= 2) ? 4'h1 : 4'hF;
    end
    start = 0;
    mask = 4'hF;

    // Reset while channel 2 is selected
    ivec = 4'hF;
    start = 1;
    for (int c = 0; c <= 4; c++) begin
      edge1();
      #1;
      start = 0;
    end
    chk("abort.pre_sel", sel0, 2);
    rst = 1;
    #1;
    chk("abort.sel", sel0, 0);
    chk("abort.busy", busy0, 0);
    chk("abort.sample", sample0, 0);
    chk("abort.valid", valid0, 0);
    edge1();
    #1;
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      edge1();
      chk("abort.no_valid", valid0, 0);
      chk("abort.no_sample", sample0, 0);
      #1;
    end
    ivec = 4'h9;
    start = 1;
    for (int c = 0; c <= 9; c++) begin
      edge1();
      chk($sformatf("post%0d.valid", c), valid0, (c == 8) ? 4'd1 : 4'd0);
      if (c == 8) chk("post.sample", sample0, 4'h9);
      #1;
      start = 0;
    end

    // Random traffic, including async resets, against the model
    use_mux = 0;
    repeat (3000) begin
      edge1();
      #1;
      start = ($urandom_range(0, 3) == 0);
      mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      y_rnd0 = 1'($urandom);
      y_rnd1 = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 0;
    edge1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
